// File: rtl/axi_full_burst_master_pkg.sv
// Shared types and constants for the AXI4-full burst master.
package axi_full_pkg;

   // AXI response codes
   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_e;

   // AXI burst types
   localparam logic [1:0] FIXED = 2'b00;
   localparam logic [1:0] INCR  = 2'b01;
   localparam logic [1:0] WRAP  = 2'b10;

   // Master sequencing states
   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      WRESP,
      READ,
      DONE
   } state_e;

   // Ceiling log2, used to derive AxSIZE from the data width in bytes
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

endpackage

// File: rtl/axi_full_burst_master_if.sv
// AXI4-full bus bundle between the burst master and its slave memory.
interface axi_full_burst_master_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [7:0]              awlen;
   logic [2:0]              awsize;
   logic [1:0]              awburst;
   logic                    awvalid;
   logic                    awready;

   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wlast;
   logic                    wvalid;
   logic                    wready;

   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;

   logic [ADDR_WIDTH-1:0]   araddr;
   logic [7:0]              arlen;
   logic [2:0]              arsize;
   logic [1:0]              arburst;
   logic                    arvalid;
   logic                    arready;

   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rlast;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready,
      output araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready,
      input  araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rdata, rresp, rlast, rvalid,
      input  rready
   );

endinterface

// File: rtl/axi_full_burst_master.sv
// AXI4-full burst master: on an INIT rising edge, writes an incrementing
// pattern (1, 2, ...) as one INCR burst, reads the same burst back and
// compares it. TXN_DONE is held after read-back; ERROR is sticky per run.
// Optional build macro AXI_FULL_RESP_CHECK_EN: non-OKAY BRESP/RRESP also
// raise ERROR; when undefined the response fields are ignored.
module axi_full_burst_master
   import axi_full_pkg::*;
#(
   parameter int unsigned                   C_M_AXI_ADDR_WIDTH         = 32,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_TARGET_SLAVE_BASE_ADDR = '0,
   parameter int unsigned                   C_M_AXI_BURST_LEN          = 8,
   parameter int unsigned                   C_M_AXI_DATA_WIDTH         = 32
) (
   input  logic                    M_AXI_ACLK,
   input  logic                    M_AXI_ARESETN,
   input  logic                    INIT_AXI_TXN,
   output logic                    TXN_DONE,
   output logic                    ERROR,
   axi_full_burst_master_if.master m_axi
);

   localparam int unsigned DW        = C_M_AXI_DATA_WIDTH;
   localparam logic [7:0]  LAST_BEAT = 8'(C_M_AXI_BURST_LEN - 1);
   localparam logic [2:0]  AXSIZE    = 3'(clog2(C_M_AXI_DATA_WIDTH / 8));
   localparam logic [DW-1:0] ONE     = {{(DW-1){1'b0}}, 1'b1};

   state_e        state;
   logic          init_q;
   logic [7:0]    w_beat;
   logic [7:0]    r_beat;
   logic [DW-1:0] wdata_q;
   logic          awvalid_q;
   logic          wvalid_q;
   logic          wlast_q;
   logic          bready_q;
   logic          arvalid_q;
   logic          rready_q;
   logic          aw_done;
   logic          w_done;
   logic          txn_done_q;
   logic          error_q;

   logic          start;
   logic          aw_hs;
   logic          w_hs;
   logic          b_hs;
   logic          ar_hs;
   logic          r_hs;
   logic          aw_all;
   logic          w_all;
   logic [DW-1:0] r_expect;
   logic          r_mismatch;
   logic          r_last_bad;
   logic          b_resp_err;
   logic          r_resp_err;

   // Handshake decode, read-back comparator and start edge detect
   always_comb begin
      start      = INIT_AXI_TXN & ~init_q;
      aw_hs      = awvalid_q & m_axi.awready;
      w_hs       = wvalid_q & m_axi.wready;
      b_hs       = bready_q & m_axi.bvalid;
      ar_hs      = arvalid_q & m_axi.arready;
      r_hs       = rready_q & m_axi.rvalid;
      // W can finish before AW: the write phase ends when both have completed
      aw_all     = aw_done | aw_hs;
      w_all      = w_done | (w_hs & wlast_q);
      r_expect   = {{(DW-8){1'b0}}, r_beat} + ONE;
      r_mismatch = (m_axi.rdata != r_expect);
      r_last_bad = (m_axi.rlast != (r_beat == LAST_BEAT));
   end

`ifdef AXI_FULL_RESP_CHECK_EN
   assign b_resp_err = (m_axi.bresp != OKAY);
   assign r_resp_err = (m_axi.rresp != OKAY);
`else
   logic unused_resp;
   assign unused_resp = ^{m_axi.bresp, m_axi.rresp};
   assign b_resp_err  = 1'b0;
   assign r_resp_err  = 1'b0;
`endif

   // Write-then-read sequencer with registered channel controls
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         state      <= IDLE;
         init_q     <= 1'b0;
         w_beat     <= '0;
         r_beat     <= '0;
         wdata_q    <= '0;
         awvalid_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         wlast_q    <= 1'b0;
         bready_q   <= 1'b0;
         arvalid_q  <= 1'b0;
         rready_q   <= 1'b0;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
         txn_done_q <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         init_q <= INIT_AXI_TXN;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state      <= WRITE;
                  awvalid_q  <= 1'b1;
                  wvalid_q   <= 1'b1;
                  wdata_q    <= ONE;
                  wlast_q    <= (LAST_BEAT == 8'd0);
                  w_beat     <= '0;
                  r_beat     <= '0;
                  aw_done    <= 1'b0;
                  w_done     <= 1'b0;
                  txn_done_q <= 1'b0;
                  error_q    <= 1'b0;
               end
            end
            WRITE: begin
               if (aw_hs) begin
                  awvalid_q <= 1'b0;
                  aw_done   <= 1'b1;
               end
               if (w_hs) begin
                  if (wlast_q) begin
                     wvalid_q <= 1'b0;
                     wlast_q  <= 1'b0;
                     w_done   <= 1'b1;
                  end else begin
                     w_beat  <= w_beat + 8'd1;
                     wdata_q <= wdata_q + ONE;
                     wlast_q <= ((w_beat + 8'd1) == LAST_BEAT);
                  end
               end
               if (aw_all && w_all) begin
                  state    <= WRESP;
                  bready_q <= 1'b1;
               end
            end
            WRESP: begin
               if (b_hs) begin
                  bready_q  <= 1'b0;
                  arvalid_q <= 1'b1;
                  state     <= READ;
                  if (b_resp_err) error_q <= 1'b1;
               end
            end
            READ: begin
               if (ar_hs) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
               end
               if (r_hs) begin
                  if (r_mismatch || r_last_bad || r_resp_err) error_q <= 1'b1;
                  // Early RLAST and a missing RLAST on the final beat both end the read
                  if (m_axi.rlast || (r_beat == LAST_BEAT)) begin
                     rready_q   <= 1'b0;
                     txn_done_q <= 1'b1;
                     state      <= DONE;
                  end else begin
                     r_beat <= r_beat + 8'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign m_axi.awaddr  = C_M_TARGET_SLAVE_BASE_ADDR;
   assign m_axi.awlen   = LAST_BEAT;
   assign m_axi.awsize  = AXSIZE;
   assign m_axi.awburst = INCR;
   assign m_axi.awvalid = awvalid_q;
   assign m_axi.wdata   = wdata_q;
   assign m_axi.wstrb   = '1;
   assign m_axi.wlast   = wlast_q;
   assign m_axi.wvalid  = wvalid_q;
   assign m_axi.bready  = bready_q;
   assign m_axi.araddr  = C_M_TARGET_SLAVE_BASE_ADDR;
   assign m_axi.arlen   = LAST_BEAT;
   assign m_axi.arsize  = AXSIZE;
   assign m_axi.arburst = INCR;
   assign m_axi.arvalid = arvalid_q;
   assign m_axi.rready  = rready_q;
   assign TXN_DONE      = txn_done_q;
   assign ERROR         = error_q;

endmodule

// File: tb/tb_axi_full_burst_master.sv
// Scoreboard bench for axi_full_burst_master: a reactive memory slave,
// directed scenarios pushing expected beats/results, and a monitor that
// pops and compares whenever the DUT presents a handshake or completion.
module tb_axi_full_burst_master;
   import axi_full_pkg::*;

   localparam int unsigned LEN  = 8;
   localparam int unsigned DW   = 32;
   localparam int unsigned AW   = 32;
   localparam logic [31:0] BASE = 32'h0000_0400;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic init  = 1'b0;
   logic txn_done;
   logic error;

   axi_full_burst_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   axi_full_burst_master #(
      .C_M_AXI_ADDR_WIDTH        (AW),
      .C_M_TARGET_SLAVE_BASE_ADDR(BASE),
      .C_M_AXI_BURST_LEN         (LEN),
      .C_M_AXI_DATA_WIDTH        (DW)
   ) dut (
      .M_AXI_ACLK   (clk),
      .M_AXI_ARESETN(rst_n),
      .INIT_AXI_TXN (init),
      .TXN_DONE     (txn_done),
      .ERROR        (error),
      .m_axi        (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // scoreboard queues
   logic [DW:0] exp_w[$];
   bit          exp_rerr[$];
   bit          exp_res[$];

   // slave configuration and state
   bit          bp          = 1'b0;
   int          corrupt_idx = -1;
   int          early_idx   = -1;
   logic [1:0]  bresp_cfg   = OKAY;
   bit          aw_seen, w_seen, r_active;
   int          widx, ridx;
   int          wcount      = 0;
   logic [DW-1:0] mem [0:255];

   function automatic logic rdy();
      return bp ? ($urandom_range(0, 9) >= 3) : 1'b1;
   endfunction

   // Memory slave: drives on the falling edge, records handshakes 1 ns later
   initial begin : slave
      bit b_hs, ar_hs, r_hs, r_last_hs;
      b_hs = 0; ar_hs = 0; r_hs = 0; r_last_hs = 0;
      bus.awready = 0; bus.wready = 0; bus.arready = 0;
      bus.bvalid = 0; bus.bresp = OKAY;
      bus.rvalid = 0; bus.rdata = '0; bus.rresp = OKAY; bus.rlast = 0;
      aw_seen = 0; w_seen = 0; r_active = 0; widx = 0; ridx = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            bus.awready = 0; bus.wready = 0; bus.arready = 0;
            bus.bvalid = 0; bus.rvalid = 0; bus.rlast = 0;
            aw_seen = 0; w_seen = 0; r_active = 0; widx = 0; ridx = 0;
            b_hs = 0; ar_hs = 0; r_hs = 0;
         end else begin
            if (b_hs) begin bus.bvalid = 0; aw_seen = 0; w_seen = 0; widx = 0; end
            if (ar_hs) begin r_active = 1; ridx = 0; end
            if (r_hs) begin
               bus.rvalid = 0; bus.rlast = 0;
               if (r_last_hs) r_active = 0; else ridx++;
            end
            b_hs = 0; ar_hs = 0; r_hs = 0;
            bus.awready = rdy();
            bus.wready  = rdy();
            bus.arready = rdy();
            if (!bus.bvalid && aw_seen && w_seen && rdy()) begin
               bus.bvalid = 1; bus.bresp = bresp_cfg;
            end
            if (!bus.rvalid && r_active && rdy()) begin
               bus.rvalid = 1;
               bus.rresp  = OKAY;
               bus.rdata  = (ridx == corrupt_idx) ? 32'hDEAD_BEEF : mem[ridx];
               bus.rlast  = (ridx == int'(LEN) - 1) || (ridx == early_idx);
            end
         end
         #1;
         if (rst_n) begin
            if (bus.awvalid && bus.awready) aw_seen = 1;
            if (bus.wvalid && bus.wready) begin
               mem[widx] = bus.wdata; widx++; wcount++;
               if (bus.wlast) w_seen = 1;
            end
            b_hs      = bus.bvalid && bus.bready;
            ar_hs     = bus.arvalid && bus.arready;
            r_hs      = bus.rvalid && bus.rready;
            r_last_hs = bus.rlast;
         end
      end
   end

   // Monitor: pops expectations on each DUT handshake / completion
   initial begin : monitor
      bit aw_stall, w_stall, ar_stall, r_pend, r_pend_val, prev_done;
      logic [31:0] aw_save, ar_save;
      logic [DW:0] w_save;
      aw_stall = 0; w_stall = 0; ar_stall = 0; r_pend = 0; r_pend_val = 0; prev_done = 0;
      aw_save = '0; ar_save = '0; w_save = '0;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_n) begin
            aw_stall = 0; w_stall = 0; ar_stall = 0; r_pend = 0; prev_done = 0;
         end else begin
            if (r_pend) begin
               check("error_after_rbeat", error, r_pend_val);
               r_pend = 0;
            end
            if (aw_stall) check("aw_hold", {bus.awvalid, bus.awaddr}, {1'b1, aw_save});
            if (w_stall)  check("w_hold", {bus.wvalid, bus.wlast, bus.wdata}, {1'b1, w_save});
            if (ar_stall) check("ar_hold", {bus.arvalid, bus.araddr}, {1'b1, ar_save});
            aw_stall = bus.awvalid && !bus.awready; aw_save = bus.awaddr;
            w_stall  = bus.wvalid && !bus.wready;   w_save  = {bus.wlast, bus.wdata};
            ar_stall = bus.arvalid && !bus.arready; ar_save = bus.araddr;
            if (bus.awvalid && bus.awready)
               check("aw_fields", {bus.awaddr, bus.awlen, bus.awsize, bus.awburst},
                     {BASE, 8'(LEN - 1), 3'd2, 2'b01});
            if (bus.arvalid && bus.arready)
               check("ar_fields", {bus.araddr, bus.arlen, bus.arsize, bus.arburst},
                     {BASE, 8'(LEN - 1), 3'd2, 2'b01});
            if (bus.wvalid && bus.wready) begin
               if (exp_w.size() == 0) check("w_unexpected_beat", 1'b1, 1'b0);
               else check("w_beat", {bus.wlast, bus.wdata}, exp_w.pop_front());
               check("w_strb", bus.wstrb, 4'hF);
            end
            if (bus.rvalid && bus.rready) begin
               if (exp_rerr.size() == 0) check("r_unexpected_beat", 1'b1, 1'b0);
               else begin r_pend = 1; r_pend_val = exp_rerr.pop_front(); end
            end
            if (txn_done && !prev_done) begin
               if (exp_res.size() == 0) check("done_unexpected", 1'b1, 1'b0);
               else check("final_error", error, exp_res.pop_front());
            end
            prev_done = txn_done;
         end
      end
   end

   task automatic check_idle(input string name);
      check(name, {bus.awvalid, bus.wvalid, bus.wlast, bus.bready,
                   bus.arvalid, bus.rready, txn_done, error}, 8'h00);
   endtask

   task automatic push_writes();
      for (int k = 0; k < int'(LEN); k++) begin
         logic [DW-1:0] d;
         d = DW'(k + 1);
         exp_w.push_back({(k == int'(LEN) - 1), d});
      end
   endtask

   task automatic pulse_init();
      @(negedge clk); init = 1;
      @(negedge clk);
      @(negedge clk); init = 0;
   endtask

   // One run: nread read beats, ERROR expected from read beat err_from onward
   task automatic run_txn(input int nread, input int err_from, input bit fin_err);
      bit seen;
      push_writes();
      for (int k = 0; k < nread; k++) exp_rerr.push_back(k >= err_from);
      exp_res.push_back(fin_err);
      pulse_init();
      #1;
      check("start_clears", {txn_done, error}, 2'b00);
      seen = 0;
      for (int c = 0; c < 3000 && !seen; c++) begin
         @(negedge clk);
         #1;
         seen = txn_done;
      end
      if (!seen) begin
         check("txn_done_timeout", 1'b0, 1'b1);
         exp_w.delete(); exp_rerr.delete(); exp_res.delete();
      end
      repeat (3) @(negedge clk);
      #1;
      check("w_queue_drained", exp_w.size(), 0);
      check("r_queue_drained", exp_rerr.size(), 0);
      check("res_queue_drained", exp_res.size(), 0);
   endtask

   initial begin : stimulus
      #1 rst_n = 0;
      repeat (3) @(negedge clk);
      #2 check_idle("reset_outputs");
      @(negedge clk); #2 rst_n = 1;

      // 1: always-ready slave
      run_txn(LEN, 999, 0);

      // 2: random back-pressure
      bp = 1;
      run_txn(LEN, 999, 0);
      run_txn(LEN, 999, 0);
      bp = 0;

      // 3: corrupted read beat 3, then a clean rerun
      corrupt_idx = 2;
      run_txn(LEN, 2, 1);
      corrupt_idx = -1;
      run_txn(LEN, 999, 0);

      // 4: early RLAST on beat 6 of 8
      early_idx = 5;
      run_txn(6, 5, 1);
      early_idx = -1;

      // 5: reset while write beat 4 is on the bus
      wcount = 0;
      push_writes();
      pulse_init();
      begin
         bit hit;
         hit = 0;
         for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk); #2;
            hit = (wcount >= 4);
         end
         if (!hit) check("reset_point_timeout", 1'b0, 1'b1);
      end
      rst_n = 0;
      exp_w.delete(); exp_rerr.delete(); exp_res.delete();
      #2 check_idle("midburst_reset_outputs");
      repeat (3) @(negedge clk);
      #1 check_idle("reset_held_outputs");
      #1 rst_n = 1;
      run_txn(LEN, 999, 0);

      // 6: SLVERR write response
      bresp_cfg = SLVERR;
`ifdef AXI_FULL_RESP_CHECK_EN
      run_txn(LEN, 0, 1);
`else
      run_txn(LEN, 999, 0);
`endif
      bresp_cfg = OKAY;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi_full_burst_master.md
Name: axi_full_burst_master

Overview:
AXI4-full master stage that feeds the S00_AXI slave memory of the axi_full IP. An INIT pulse starts one incrementing-data write burst to a fixed base address, then a read-back burst of the same length. The master compares the read data against the pattern it wrote. It reports completion on TXN_DONE and any mismatch on ERROR. The example design's M00_AXI_INIT_AXI_TXN, M00_AXI_TXN_DONE and M00_AXI_ERROR bench signals connect to this block.

Parameters:
C_M_TARGET_SLAVE_BASE_ADDR, 32'h0000_0000, byte address used by both bursts
C_M_AXI_BURST_LEN, 8, beats per burst (1..256)
C_M_AXI_ADDR_WIDTH, 32, address width
C_M_AXI_DATA_WIDTH, 32, data width (32 or 64)

Ports:
M_AXI_ACLK  in  1  clock
M_AXI_ARESETN  in  1  asynchronous active-low reset
INIT_AXI_TXN  in  1  start request; rising edge is detected
TXN_DONE  out  1  high after read-back completes; held
ERROR  out  1  sticky compare/protocol error
M_AXI_AWADDR  out  ADDR_WIDTH  write address
M_AXI_AWLEN  out  8  BURST_LEN-1
M_AXI_AWSIZE  out  3  clog2(DATA_WIDTH/8)
M_AXI_AWBURST  out  2  2'b01 (INCR)
M_AXI_AWVALID / M_AXI_AWREADY  out/in  1  AW handshake
M_AXI_WDATA  out  DATA_WIDTH  write beat
M_AXI_WSTRB  out  DATA_WIDTH/8  all ones
M_AXI_WLAST  out  1  final write beat
M_AXI_WVALID / M_AXI_WREADY  out/in  1  W handshake
M_AXI_BRESP  in  2  write response
M_AXI_BVALID / M_AXI_BREADY  in/out  1  B handshake
M_AXI_ARADDR  out  ADDR_WIDTH  read address
M_AXI_ARLEN / M_AXI_ARSIZE / M_AXI_ARBURST  out  8/3/2  same values as AW
M_AXI_ARVALID / M_AXI_ARREADY  out/in  1  AR handshake
M_AXI_RDATA  in  DATA_WIDTH  read beat
M_AXI_RRESP  in  2  read response
M_AXI_RLAST  in  1  final read beat
M_AXI_RVALID / M_AXI_RREADY  in/out  1  R handshake

Behaviour:
- Reset (asynchronous assert, synchronous release): state IDLE. All VALID/READY outputs, WLAST, TXN_DONE and ERROR are 0. Beat counters are 0. INIT edge register is 0.
- Start condition: INIT_AXI_TXN==1 while its registered copy is 0. A start seen outside IDLE/DONE is ignored.
- FSM transitions:
  - IDLE/DONE -> WRITE on start. The same transition clears TXN_DONE and ERROR.
  - WRITE -> WRESP on the accepted WLAST beat, or on the AW accept if the WLAST beat was accepted earlier.
  - WRESP -> READ on BVALID&BREADY.
  - READ -> DONE on the accepted RLAST beat.
  - DONE sets TXN_DONE=1.
- AW channel: AWVALID rises one cycle after start. It holds with stable AWADDR/AWLEN until AWREADY, then drops the next cycle. One AW per run.
- W channel: WVALID rises in the same cycle as AWVALID, so W may complete before AW.
  - Beat k (0-based) carries WDATA=k+1, zero-extended.
  - Data and WLAST stay stable while WVALID&!WREADY.
  - WLAST=1 exactly when k==BURST_LEN-1. WVALID drops after that beat is accepted.
- B channel: BREADY=1 only in WRESP, for one accepted response.
- AR channel: ARVALID rises on entering READ and holds until ARREADY.
- R channel:
  - RREADY=1 in READ after the AR accept.
  - Each accepted beat k is compared to k+1; a mismatch sets ERROR.
  - RLAST with k!=BURST_LEN-1, or no RLAST at k==BURST_LEN-1, sets ERROR. In the second case the FSM still moves to DONE on that beat.
- BURST_LEN=1: first beat carries WLAST and RLAST checks apply at k=0.
- Reset mid-burst: abandons the transaction immediately and returns to IDLE. No outstanding handshake is completed.

Optional Feature:
AXI_FULL_RESP_CHECK_EN
- Defined: BRESP!=2'b00 or any RRESP!=2'b00 sets ERROR.
- Undefined: BRESP and RRESP are ignored; ERROR reflects data/RLAST checks only.

Decomposition:
- Package axi_full_pkg holds:
  - resp codes OKAY/EXOKAY/SLVERR/DECERR
  - burst type constants FIXED/INCR/WRAP
  - state enum IDLE/WRITE/WRESP/READ/DONE
  - clog2 function used for AxSIZE
- No sub-module. Beat counters, the pattern generator and the comparator are small enough to stay inline.

Test Plan:
1. Reset, then INIT pulse; memory slave with always-ready handshakes, LEN=8. Required: WDATA 1..8, WLAST on beat 8, read 1..8 -> TXN_DONE=1, ERROR=0.
2. Random READY back-pressure on AW/W/B/AR/R (30% low). Required: VALID and data stable while stalled, same final result as scenario 1.
3. Slave corrupts read beat 3 to 0xDEAD_BEEF. Required: ERROR=1 on that beat, TXN_DONE=1 at end, second INIT clears ERROR and the clean run passes.
4. Slave asserts RLAST on beat 6 of 8. Required: ERROR=1, FSM reaches DONE.
5. Assert ARESETN low during write beat 4, release, then INIT. Required: outputs 0 during reset, fresh run completes with ERROR=0.
6. With AXI_FULL_RESP_CHECK_EN defined, slave returns BRESP=2'b10. Required: ERROR=1. Without the macro: ERROR=0.
